// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, derived constants and output types
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  localparam int SQ_SIZE_DEF = 16;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [7:0]       rgb332_t;

  localparam rgb332_t FG_COLOR_DEF = 8'hFC;
  localparam rgb332_t BG_COLOR_DEF = 8'h03;

  typedef struct packed {
    logic    hsync;
    logic    vsync;
    logic    de;
    rgb332_t rgb;
    logic    frame_tick;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_RESET = '{
    hsync:      1'b1,
    vsync:      1'b1,
    de:         1'b0,
    rgb:        8'h00,
    frame_tick: 1'b0
  };

  function automatic cnt_t to_cnt(input int value);
    return cnt_t'(value);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running pixel/line counters with raw sync, active and blank decode
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output cnt_t       h_cnt,
  output cnt_t       v_cnt,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       blank,
  output logic       tick_raw
);

  localparam cnt_t H_LAST    = to_cnt(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST    = to_cnt(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT_C   = to_cnt(H_ACTIVE);
  localparam cnt_t V_ACT_C   = to_cnt(V_ACTIVE);
  localparam cnt_t H_SS      = to_cnt(H_ACTIVE + H_FP);
  localparam cnt_t H_SE      = to_cnt(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t V_SS      = to_cnt(V_ACTIVE + V_FP);
  localparam cnt_t V_SE      = to_cnt(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam cnt_t CNT_ONE   = to_cnt(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
    end else begin
      h_cnt <= h_cnt + CNT_ONE;
    end
  end

  assign active    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hsync_raw = !((h_cnt >= H_SS) && (h_cnt <= H_SE));
  assign vsync_raw = !((v_cnt >= V_SS) && (v_cnt <= V_SE));
  assign blank     = (v_cnt >= V_ACT_C);
  assign tick_raw  = (h_cnt == '0) && (v_cnt == V_ACT_C);

endmodule

// File: rtl/vga_square_renderer.sv
// rtl/vga_square_renderer.sv - VGA output with a filled square whose position only updates in vertical blank
module vga_square_renderer
  import vga_pkg::*;
#(
  parameter int      H_ACTIVE = H_ACTIVE_DEF,
  parameter int      H_FP     = H_FP_DEF,
  parameter int      H_SYNC   = H_SYNC_DEF,
  parameter int      H_BP     = H_BP_DEF,
  parameter int      V_ACTIVE = V_ACTIVE_DEF,
  parameter int      V_FP     = V_FP_DEF,
  parameter int      V_SYNC   = V_SYNC_DEF,
  parameter int      V_BP     = V_BP_DEF,
  parameter int      SQ_SIZE  = SQ_SIZE_DEF,
  parameter rgb332_t FG_COLOR = FG_COLOR_DEF,
  parameter rgb332_t BG_COLOR = BG_COLOR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pos_valid,
  input  logic [CNT_W-1:0] pos_x,
  input  logic [CNT_W-1:0] pos_y,
  output logic             pos_ready,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [7:0]       rgb,
  output logic             frame_tick
);

  localparam logic [CNT_W:0] SQ_EXT = (CNT_W+1)'(SQ_SIZE);

  cnt_t     h_cnt;
  cnt_t     v_cnt;
  logic     active;
  logic     hsync_raw;
  logic     vsync_raw;
  logic     blank;
  logic     tick_raw;

  cnt_t     sq_x;
  cnt_t     sq_y;

  logic [CNT_W:0] h_ext;
  logic [CNT_W:0] v_ext;
  logic [CNT_W:0] x_lo;
  logic [CNT_W:0] x_hi;
  logic [CNT_W:0] y_lo;
  logic [CNT_W:0] y_hi;
  logic           hit;

  vga_out_t out_d;
  vga_out_t out_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .blank     (blank),
    .tick_raw  (tick_raw)
  );

  // Accepting only in blank means the square never moves mid-frame.
  assign pos_ready = blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_x <= '0;
      sq_y <= '0;
    end else if (pos_valid && pos_ready) begin
      sq_x <= pos_x;
      sq_y <= pos_y;
    end
  end

  // One extra bit keeps sq+SQ_SIZE from wrapping, so edge squares clip instead.
  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};
  assign x_lo  = {1'b0, sq_x};
  assign y_lo  = {1'b0, sq_y};
  assign x_hi  = x_lo + SQ_EXT;
  assign y_hi  = y_lo + SQ_EXT;
  assign hit   = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);

  always_comb begin
    out_d            = VGA_OUT_RESET;
    out_d.hsync      = hsync_raw;
    out_d.vsync      = vsync_raw;
    out_d.de         = active;
    out_d.rgb        = active ? (hit ? FG_COLOR : BG_COLOR) : 8'h00;
    out_d.frame_tick = tick_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= VGA_OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign hsync      = out_q.hsync;
  assign vsync      = out_q.vsync;
  assign de         = out_q.de;
  assign rgb        = out_q.rgb;
  assign frame_tick = out_q.frame_tick;

endmodule

// File: tb/tb_vga_square_renderer.sv
// tb/tb_vga_square_renderer.sv - directed bench on a reduced 64x48 raster
module tb_vga_square_renderer;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 48;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int SQ  = 4;
  localparam int HT  = 80;
  localparam int VT  = 55;
  localparam logic [7:0] FG = 8'hFC;
  localparam logic [7:0] BG = 8'h03;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pos_valid = 1'b0;
  logic [9:0] pos_x = '0;
  logic [9:0] pos_y = '0;
  logic       pos_ready;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [7:0] rgb;
  logic       frame_tick;

  always #5 clk = ~clk;

  vga_square_renderer #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SQ_SIZE  (SQ), .FG_COLOR (FG), .BG_COLOR (BG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pos_valid  (pos_valid),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_ready  (pos_ready),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb        (rgb),
    .frame_tick (frame_tick)
  );

  int vectors = 0;
  int errors  = 0;

  int oh, ov;
  int de_cnt, hs_low, vs_low, fg_cnt, tick_cnt, tick_h, tick_v, first_hs;
  int de_err, hs_err, vs_err, blank_err, color_err;
  int min_x, max_x, min_y, max_y;

  int off_n;
  int off_line[3];
  int off_x[3];
  int off_y[3];
  int off_ready[3];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    de_cnt = 0; hs_low = 0; vs_low = 0; fg_cnt = 0; tick_cnt = 0;
    tick_h = -1; tick_v = -1; first_hs = -1;
    de_err = 0; hs_err = 0; vs_err = 0; blank_err = 0; color_err = 0;
    min_x = 1000; max_x = -1; min_y = 1000; max_y = -1;
  endtask

  task automatic add_offer(input int line, input int x, input int y);
    off_line[off_n] = line;
    off_x[off_n] = x;
    off_y[off_n] = y;
    off_ready[off_n] = -1;
    off_n++;
  endtask

  task automatic sample();
    bit exp_de, exp_hs_low, exp_vs_low;
    @(posedge clk);
    @(negedge clk);
    exp_de     = (oh < HA) && (ov < VA);
    exp_hs_low = (oh >= HA + HFP) && (oh < HA + HFP + HS);
    exp_vs_low = (ov >= VA + VFP) && (ov < VA + VFP + VS);
    if (de !== exp_de) de_err++;
    if (de === 1'b1) de_cnt++;
    if (hsync !== !exp_hs_low) hs_err++;
    if (hsync === 1'b0) begin
      hs_low++;
      if (ov == 0 && first_hs < 0) first_hs = oh;
    end
    if (vsync !== !exp_vs_low) vs_err++;
    if (vsync === 1'b0) vs_low++;
    if (!exp_de) begin
      if (rgb !== 8'h00) blank_err++;
    end else if (rgb === FG) begin
      fg_cnt++;
      if (oh < min_x) min_x = oh;
      if (oh > max_x) max_x = oh;
      if (ov < min_y) min_y = ov;
      if (ov > max_y) max_y = ov;
    end else if (rgb !== BG) begin
      color_err++;
    end
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      tick_h = oh;
      tick_v = ov;
    end
    pos_valid = 1'b0;
    for (int k = 0; k < off_n; k++) begin
      if (off_line[k] == ov && oh == 10) begin
        pos_valid = 1'b1;
        pos_x = 10'(off_x[k]);
        pos_y = 10'(off_y[k]);
        off_ready[k] = int'(pos_ready);
      end
    end
    oh++;
    if (oh == HT) begin
      oh = 0;
      ov = (ov == VT - 1) ? 0 : ov + 1;
    end
  endtask

  task automatic frame_checks(input string tag, input int exp_fg,
                              input int x0, input int x1, input int y0, input int y1);
    check({tag, " de_cnt"}, de_cnt, HA * VA);
    check({tag, " hsync_low_cnt"}, hs_low, HS * VT);
    check({tag, " vsync_low_cnt"}, vs_low, VS * HT);
    check({tag, " de_pos_err"}, de_err, 0);
    check({tag, " hsync_pos_err"}, hs_err, 0);
    check({tag, " vsync_pos_err"}, vs_err, 0);
    check({tag, " blank_rgb_err"}, blank_err, 0);
    check({tag, " bg_color_err"}, color_err, 0);
    check({tag, " tick_cnt"}, tick_cnt, 1);
    check({tag, " tick_col"}, tick_h, 0);
    check({tag, " tick_line"}, tick_v, VA);
    check({tag, " fg_cnt"}, fg_cnt, exp_fg);
    if (exp_fg > 0) begin
      check({tag, " fg_min_x"}, min_x, x0);
      check({tag, " fg_max_x"}, max_x, x1);
      check({tag, " fg_min_y"}, min_y, y0);
      check({tag, " fg_max_y"}, max_y, y1);
    end
    for (int k = 0; k < off_n; k++)
      check($sformatf("%s offer%0d_ready", tag, k), off_ready[k], (off_line[k] >= VA) ? 1 : 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " hsync"}, int'(hsync), 1);
    check({tag, " vsync"}, int'(vsync), 1);
    check({tag, " de"}, int'(de), 0);
    check({tag, " rgb"}, int'(rgb), 0);
    check({tag, " frame_tick"}, int'(frame_tick), 0);
    check({tag, " pos_ready"}, int'(pos_ready), 0);
  endtask

  initial begin
    oh = 0; ov = 0; off_n = 0;
    clear_stats();

    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Frame 0: square still at reset position (0,0); one refused and one accepted offer.
    off_n = 0;
    add_offer(5, 30, 30);
    add_offer(50, 20, 10);
    sample();
    check("first_out de", de_cnt, 1);
    check("first_out rgb", fg_cnt, 1);
    repeat (HT * VT - 1) sample();
    check("f0 first_hsync_col", first_hs, HA + HFP);
    frame_checks("f0", SQ * SQ, 0, 3, 0, 3);

    // Frame 1: (20,10); refused active offer, then two blank transfers, last wins.
    clear_stats(); off_n = 0;
    add_offer(20, 30, 30);
    add_offer(49, 5, 5);
    add_offer(52, 40, 40);
    repeat (HT * VT) sample();
    frame_checks("f1", SQ * SQ, 20, 23, 10, 13);

    // Frame 2: (40,40); offer clipped corner position.
    clear_stats(); off_n = 0;
    add_offer(50, 62, 46);
    repeat (HT * VT) sample();
    frame_checks("f2", SQ * SQ, 40, 43, 40, 43);

    // Frame 3: clipped to 2x2 in the bottom-right corner; offer off-screen position.
    clear_stats(); off_n = 0;
    add_offer(50, 70, 50);
    repeat (HT * VT) sample();
    frame_checks("f3", 4, 62, 63, 46, 47);

    // Frame 4: fully off-screen.
    clear_stats(); off_n = 0;
    repeat (HT * VT) sample();
    frame_checks("f4", 0, 0, 0, 0, 0);

    // Reset mid-frame at line 30, then the restarted frame.
    clear_stats(); off_n = 0;
    repeat (30 * HT) sample();
    check("pre_reset tick_cnt", tick_cnt, 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset("midreset");
    rst = 1'b0;
    oh = 0; ov = 0;
    clear_stats();
    repeat (HT * VT) sample();
    frame_checks("restart", SQ * SQ, 0, 3, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
